sram_ctrl: RTL and testbench
============================

# sram_ctrl

Single-port controller between the processor control FSM and the external 16-bit asynchronous SRAM. Accepts one word read or write per request from the FSM (instruction fetch, LW, SW) and sequences the SRAM chip strobes, tri-state data bus and configurable wait states. Returns read data and a one-cycle completion pulse so the FSM can stall on memory.

## Interface
Parameters:
- WAIT_CYCLES, 1, extra ACCESS cycles beyond the first; legal range 0..15
- SRAM_ADDR_W, 18, external SRAM address width; must be at least 16

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- req  input  1  access request; accepted only on an edge where ready=1
- we  input  1  1 = write, 0 = read; sampled with req
- addr  input  16  word address; sampled with req
- wdata  input  16  write data; sampled with req
- ready  output  1  controller idle, can accept req
- done  output  1  one-cycle pulse, access complete
- rdata  output  16  last read word; held until the next read completes
- sram_addr  output  SRAM_ADDR_W  {zeros, latched addr}
- sram_dq  inout  16  SRAM data bus; driven only during writes
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  output  1 each  active-low SRAM strobes

## Operation
- States: IDLE, ACCESS, RECOVER.
- IDLE:
  - ready=1; ce_n=oe_n=we_n=ub_n=lb_n=1; dq hi-Z.
  - req=1 at an edge: latch we/addr/wdata, load wait counter with WAIT_CYCLES, go to ACCESS.
- ACCESS:
  - ready=0; ce_n=ub_n=lb_n=0.
  - Read: oe_n=0, we_n=1, dq hi-Z.
  - Write: we_n=0, oe_n=1, dq driven with latched wdata.
  - Counter≠0: decrement, stay in ACCESS.
  - Counter=0: go to RECOVER. On a read, the same edge captures sram_dq into rdata.
- RECOVER:
  - ready=0; done=1; we_n=1; oe_n=1; ce_n=0.
  - Write: dq stays driven with latched wdata (data hold after we_n rises).
  - Read: dq hi-Z.
  - Next edge: go to IDLE.
- All SRAM outputs, ready and done are decoded from registered state and latched request only. There is no combinational path from req/we/addr/wdata to any output.
- sram_addr holds the latched address from ACCESS through RECOVER and keeps its last value in IDLE.
- req while ready=0 is ignored. No queuing, no error flag. The requester must hold or re-present req.
- rdata updates only on read completion; writes leave it unchanged.
- Reset has priority over every transition, including mid-ACCESS/RECOVER:
  - next state IDLE, counter 0, done 0, all strobes high, dq hi-Z.
  - rdata cleared to 0; latched addr cleared to 0 (sram_addr=0).
  - An interrupted write may leave SRAM contents undefined at that address.

## Timing
- Reset values: ready=1, done=0, rdata=0, sram_addr=0, all *_n=1, dq hi-Z.
- Request accepted at edge E0. ACCESS occupies cycles E0..E0+WAIT_CYCLES+1. RECOVER (done=1) is the following cycle.
- req→done latency = WAIT_CYCLES+2 cycles; rdata is valid in the done cycle.
- ready returns high the cycle after done. Minimum back-to-back request period = WAIT_CYCLES+3 cycles.
- Write: we_n low for WAIT_CYCLES+1 cycles. dq driven for WAIT_CYCLES+2 cycles (ACCESS plus RECOVER).
- Read: oe_n low for WAIT_CYCLES+1 cycles. Sample point is the last ACCESS edge.

## Test plan
- Reset then idle 5 cycles -> ready=1, done=0, rdata=0x0000, all strobes high, dq hi-Z throughout.
- WAIT_CYCLES=1, write addr=0x0042, wdata=0xBEEF -> we_n low exactly 2 cycles; dq=0xBEEF for 3 cycles; sram_addr=0x00042; done pulses 3 cycles after accept; ready high next cycle.
- Read back addr=0x0042 via SRAM model -> oe_n low 2 cycles, dq never driven by DUT, rdata=0xBEEF in done cycle and held through a subsequent write of 0x1234 to 0x0043.
- req held high continuously with alternating addresses -> exactly one accept per WAIT_CYCLES+3 cycles; requests presented while ready=0 are not accepted; no strobe glitches between accesses.
- Reset asserted on the second ACCESS cycle of a write -> next cycle IDLE, we_n=1, dq hi-Z, done never pulses, rdata=0.
- WAIT_CYCLES=0 instance, read of 0xA5A5 -> done 2 cycles after accept, oe_n low 1 cycle, rdata=0xA5A5.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port bridge between the processor control FSM and a
// 16-bit asynchronous SRAM. One word read or write per request, with a
// programmable number of extra access cycles and a one-cycle done pulse.
// All SRAM-facing outputs are decoded from registered state only.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   we,
  input  logic [15:0]            addr,
  input  logic [15:0]            wdata,
  output logic                   ready,
  output logic                   done,
  output logic [15:0]            rdata,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  inout  wire  [15:0]            sram_dq,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        dq_oe;

  // State and latched-request registers; reset wins over every transition
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: accept in IDLE, count wait states, capture read data on the last ACCESS edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RECOVER;
          if (!we_q) begin
            rdata_d = sram_dq;
          end
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobe and handshake decode; write data stays on the bus through RECOVER for hold time
  always_comb begin
    ready     = (state_q == IDLE);
    done      = (state_q == RECOVER);
    sram_ce_n = (state_q == IDLE);
    sram_ub_n = (state_q == IDLE);
    sram_lb_n = (state_q == IDLE);
    sram_oe_n = !((state_q == ACCESS) && !we_q);
    sram_we_n = !((state_q == ACCESS) && we_q);
    dq_oe     = we_q && (state_q != IDLE);
  end

  assign sram_dq   = dq_oe ? wdata_q : 16'hzzzz;
  assign sram_addr = SRAM_ADDR_W'(addr_q);
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl with a WAIT_CYCLES=1 instance
// and a WAIT_CYCLES=0 instance, each attached to a small SRAM model. The
// data buses are pulled up so an undriven bus reads as 16'hFFFF.
module tb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        req1, we1, ready1, done1;
  logic [15:0] addr1, wdata1, rdata1;
  logic [17:0] sramAddr1;
  tri1  [15:0] dq1;
  logic        ceN1, oeN1, weN1, ubN1, lbN1;
  logic [15:0] mem1 [0:255];

  logic        req0, we0, ready0, done0;
  logic [15:0] addr0, wdata0, rdata0;
  logic [15:0] sramAddr0;
  tri1  [15:0] dq0;
  logic        ceN0, oeN0, weN0, ubN0, lbN0;
  logic [15:0] mem0 [0:255];

  int checkCount = 0;
  int passCount  = 0;

  sram_ctrl #(.WAIT_CYCLES(1), .SRAM_ADDR_W(18)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .ready(ready1), .done(done1), .rdata(rdata1), .sram_addr(sramAddr1), .sram_dq(dq1),
    .sram_ce_n(ceN1), .sram_oe_n(oeN1), .sram_we_n(weN1), .sram_ub_n(ubN1), .sram_lb_n(lbN1)
  );

  sram_ctrl #(.WAIT_CYCLES(0), .SRAM_ADDR_W(16)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .done(done0), .rdata(rdata0), .sram_addr(sramAddr0), .sram_dq(dq0),
    .sram_ce_n(ceN0), .sram_oe_n(oeN0), .sram_we_n(weN0), .sram_ub_n(ubN0), .sram_lb_n(lbN0)
  );

  // SRAM models: drive the bus while selected and output-enabled, store while write-enabled
  assign dq1 = (!ceN1 && !oeN1) ? mem1[sramAddr1[7:0]] : 16'hzzzz;
  assign dq0 = (!ceN0 && !oeN0) ? mem0[sramAddr0[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ceN1 && !weN1) mem1[sramAddr1[7:0]] <= dq1;
  end

  always @(posedge clk) begin
    if (!ceN0 && !weN0) mem0[sramAddr0[7:0]] <= dq0;
  end

  task automatic test_reset();
    reset = 1'b1;
    req1 = 1'b0; we1 = 1'b0; addr1 = 16'd0; wdata1 = 16'd0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 16'd0; wdata0 = 16'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkCount++;
      if (ready1 !== 1'b1 || done1 !== 1'b0) $display("[TB] FAIL reset_handshake: got ready=%b done=%b expected ready=1 done=0", ready1, done1);
      else passCount++;
      checkCount++;
      if (rdata1 !== 16'h0000) $display("[TB] FAIL reset_rdata: got %h expected 0000", rdata1);
      else passCount++;
      checkCount++;
      if ({ceN1, oeN1, weN1, ubN1, lbN1} !== 5'b11111) $display("[TB] FAIL reset_strobes: got %b expected 11111", {ceN1, oeN1, weN1, ubN1, lbN1});
      else passCount++;
      checkCount++;
      if (dq1 !== 16'hFFFF || sramAddr1 !== 18'h0) $display("[TB] FAIL reset_bus: got dq=%h addr=%h expected dq=FFFF addr=0", dq1, sramAddr1);
      else passCount++;
    end
    checkCount++;
    if (ready0 !== 1'b1 || rdata0 !== 16'h0000) $display("[TB] FAIL reset_w0: got ready=%b rdata=%h expected 1/0000", ready0, rdata0);
    else passCount++;
  endtask

  task automatic test_write();
    int weLow = 0, dqDrv = 0, doneCnt = 0, doneAt = -1, readyAt = -1;
    logic [17:0] addrAt1 = '0;
    logic [1:0]  laneAt1 = 2'b11;
    checkCount++;
    if (ready1 !== 1'b1) $display("[TB] FAIL write_ready_before: got %b expected 1", ready1);
    else passCount++;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0042; wdata1 = 16'hBEEF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req1 = 1'b0;
        addrAt1 = sramAddr1;
        laneAt1 = {ubN1, lbN1};
      end
      if (!weN1) weLow++;
      if (dq1 === 16'hBEEF) dqDrv++;
      if (done1) begin doneCnt++; doneAt = c; end
      if (ready1 && readyAt < 0) readyAt = c;
    end
    checkCount++;
    if (weLow != 2) $display("[TB] FAIL write_we_low: got %0d cycles expected 2", weLow);
    else passCount++;
    checkCount++;
    if (dqDrv != 3) $display("[TB] FAIL write_dq_driven: got %0d cycles expected 3", dqDrv);
    else passCount++;
    checkCount++;
    if (addrAt1 !== 18'h00042 || laneAt1 !== 2'b00) $display("[TB] FAIL write_addr: got addr=%h lanes=%b expected 00042/00", addrAt1, laneAt1);
    else passCount++;
    checkCount++;
    if (doneCnt != 1 || doneAt != 3) $display("[TB] FAIL write_done: got count=%0d at=%0d expected 1 at 3", doneCnt, doneAt);
    else passCount++;
    checkCount++;
    if (readyAt != 4) $display("[TB] FAIL write_ready_after: got %0d expected 4", readyAt);
    else passCount++;
  endtask

  task automatic test_read();
    int oeLow = 0, weLow = 0, dqBad = 0, doneAt = -1, rdataChanged = 0;
    logic [15:0] rdAtDone = 16'h0;
    logic [17:0] addrAt1 = '0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0042; wdata1 = 16'h0000;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) req1 = 1'b0;
      if (!oeN1) oeLow++;
      if (!weN1) weLow++;
      if (oeN1 && dq1 !== 16'hFFFF) dqBad++;
      if (done1) begin doneAt = c; rdAtDone = rdata1; end
    end
    checkCount++;
    if (oeLow != 2 || weLow != 0) $display("[TB] FAIL read_strobes: got oe_low=%0d we_low=%0d expected 2/0", oeLow, weLow);
    else passCount++;
    checkCount++;
    if (dqBad != 0) $display("[TB] FAIL read_dq_hiz: got %0d driven cycles expected 0", dqBad);
    else passCount++;
    checkCount++;
    if (doneAt != 3 || rdAtDone !== 16'hBEEF) $display("[TB] FAIL read_data: got done_at=%0d rdata=%h expected 3/BEEF", doneAt, rdAtDone);
    else passCount++;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0043; wdata1 = 16'h1234;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin req1 = 1'b0; addrAt1 = sramAddr1; end
      if (rdata1 !== 16'hBEEF) rdataChanged++;
    end
    checkCount++;
    if (rdataChanged != 0) $display("[TB] FAIL read_hold: got %0d changed cycles expected 0 (rdata=%h)", rdataChanged, rdata1);
    else passCount++;
    checkCount++;
    if (addrAt1 !== 18'h00043) $display("[TB] FAIL write2_addr: got %h expected 00043", addrAt1);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    int accepts = 0, badGap = 0, lastAccept = -10, glitch = 0, dones = 0, badData = 0;
    logic [17:0] addrAt2 = '0, addrAt6 = '0;
    logic [15:0] expData;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0042;
    for (int c = 0; c < 16; c++) begin
      if (c == lastAccept + 1) addr1 = (addr1 == 16'h0042) ? 16'h0043 : 16'h0042;
      if (ready1) begin
        if (lastAccept >= 0 && c - lastAccept != 4) badGap++;
        accepts++;
        lastAccept = c;
      end
      if ((!ready1 && ceN1) || (ready1 && !ceN1)) glitch++;
      if (done1) begin
        expData = (dones % 2 == 0) ? 16'hBEEF : 16'h1234;
        if (rdata1 !== expData) badData++;
        dones++;
      end
      if (c == 2) addrAt2 = sramAddr1;
      if (c == 6) addrAt6 = sramAddr1;
      @(negedge clk);
    end
    req1 = 1'b0;
    checkCount++;
    if (accepts != 4 || badGap != 0) $display("[TB] FAIL b2b_accepts: got %0d accepts %0d bad gaps expected 4/0", accepts, badGap);
    else passCount++;
    checkCount++;
    if (glitch != 0) $display("[TB] FAIL b2b_glitch: got %0d expected 0", glitch);
    else passCount++;
    checkCount++;
    if (dones != 4 || badData != 0) $display("[TB] FAIL b2b_done: got %0d dones %0d bad data expected 4/0", dones, badData);
    else passCount++;
    checkCount++;
    if (addrAt2 !== 18'h00042 || addrAt6 !== 18'h00043) $display("[TB] FAIL b2b_ignore: got %h/%h expected 00042/00043", addrAt2, addrAt6);
    else passCount++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int doneCnt = 0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0050; wdata1 = 16'h5555;
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
    checkCount++;
    if (weN1 !== 1'b0 || dq1 !== 16'h5555) $display("[TB] FAIL rst_mid_pre: got we_n=%b dq=%h expected 0/5555", weN1, dq1);
    else passCount++;
    if (done1) doneCnt++;
    reset = 1'b1;
    @(negedge clk);
    checkCount++;
    if (ready1 !== 1'b1 || weN1 !== 1'b1 || ceN1 !== 1'b1 || done1 !== 1'b0) $display("[TB] FAIL rst_mid_state: got ready=%b we_n=%b ce_n=%b done=%b expected 1/1/1/0", ready1, weN1, ceN1, done1);
    else passCount++;
    checkCount++;
    if (dq1 !== 16'hFFFF || rdata1 !== 16'h0000 || sramAddr1 !== 18'h0) $display("[TB] FAIL rst_mid_bus: got dq=%h rdata=%h addr=%h expected FFFF/0000/0", dq1, rdata1, sramAddr1);
    else passCount++;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done1) doneCnt++;
    end
    checkCount++;
    if (doneCnt != 0) $display("[TB] FAIL rst_mid_done: got %0d pulses expected 0", doneCnt);
    else passCount++;
  endtask

  task automatic test_wait0();
    int weLow = 0, oeLow = 0, doneAt = -1, readyAt = -1;
    logic [15:0] rdAtDone = 16'h0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0077; wdata0 = 16'hA5A5;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) req0 = 1'b0;
      if (!weN0) weLow++;
      if (done0 && doneAt < 0) doneAt = c;
    end
    checkCount++;
    if (weLow != 1 || doneAt != 2) $display("[TB] FAIL w0_write: got we_low=%0d done_at=%0d expected 1/2", weLow, doneAt);
    else passCount++;
    doneAt = -1;
    req0 = 1'b1; we0 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) req0 = 1'b0;
      if (!oeN0) oeLow++;
      if (done0 && doneAt < 0) begin doneAt = c; rdAtDone = rdata0; end
      if (ready0 && readyAt < 0) readyAt = c;
    end
    checkCount++;
    if (oeLow != 1 || doneAt != 2 || readyAt != 3) $display("[TB] FAIL w0_read_timing: got oe_low=%0d done_at=%0d ready_at=%0d expected 1/2/3", oeLow, doneAt, readyAt);
    else passCount++;
    checkCount++;
    if (rdAtDone !== 16'hA5A5 || sramAddr0 !== 16'h0077) $display("[TB] FAIL w0_read_data: got rdata=%h addr=%h expected A5A5/0077", rdAtDone, sramAddr0);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_write();
    test_wait0();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
